// File: rtl/ser_des_pkg.sv
// ----------------------------------------------------------------------------
// ser_des_pkg
// Definitions shared by the serializer and the deserializer so that both ends
// of the serial link agree on word width and bit-counter sizing.
//   ser_state_t          : serializer FSM states (IDLE, SHIFT)
//   SER_DES_WD_DEFAULT   : default word width for both ends of the link
//   ser_des_cnt_width()  : width of a counter that must hold 0..WD inclusive
// ----------------------------------------------------------------------------
package ser_des_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_DES_WD_DEFAULT = 8;

    // The bit counter holds "bits remaining", which reaches WD itself,
    // so it needs one more bit than $clog2(WD) alone provides.
    function automatic int ser_des_cnt_width(input int wd);
        return $clog2(wd) + 1;
    endfunction

endpackage

// File: rtl/serializer.sv
// ----------------------------------------------------------------------------
// serializer
// Parallel-to-serial converter feeding the deserializer. A word accepted over
// a valid/ready handshake is emitted LSB-first, one bit per cycle in which
// shift_en is high. A one-word holding buffer lets the next word be queued
// while the current one shifts, so words stream with no bit gaps.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous reset, active-high
//   valid_in   in   parallel word valid
//   data_in    in   parallel word [SERIALIZER_WD-1:0]
//   ready_out  out  a word can be accepted this cycle
//   shift_en   in   bit-rate strobe; a bit is emitted only when high
//   data_out   out  serial bit (LSB first)
//   valid_out  out  data_out carries a bit this cycle (one pulse per bit)
//   busy       out  a word is shifting or buffered
// ----------------------------------------------------------------------------
module serializer
    import ser_des_pkg::*;
#(
    parameter int SERIALIZER_WD = SER_DES_WD_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic [SERIALIZER_WD-1:0] data_in,
    output logic                     ready_out,
    input  logic                     shift_en,
    output logic                     data_out,
    output logic                     valid_out,
    output logic                     busy
);

    localparam int              CW       = ser_des_cnt_width(SERIALIZER_WD);
    localparam logic [CW-1:0]   CNT_FULL = CW'(SERIALIZER_WD);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    ser_state_t                 state, state_n;
    logic [SERIALIZER_WD-1:0]   sreg, sreg_n;
    logic [CW-1:0]              cnt, cnt_n;
    logic [SERIALIZER_WD-1:0]   hbuf, hbuf_n;
    logic                       hvalid, hvalid_n;
    logic                       accept;

    // The buffer is the only thing that can block a new word: while it is
    // empty a word can always go either straight into sreg or into hbuf.
    assign ready_out = !rst && !hvalid;
    assign valid_out = (state == SHIFT) && shift_en;
    assign data_out  = sreg[0];
    assign busy      = (state == SHIFT) || hvalid;
    assign accept    = valid_in && ready_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            hbuf   <= '0;
            hvalid <= 1'b0;
        end else begin
            state  <= state_n;
            sreg   <= sreg_n;
            cnt    <= cnt_n;
            hbuf   <= hbuf_n;
            hvalid <= hvalid_n;
        end
    end

    // On the last bit the next word is loaded in the same cycle (from hbuf
    // first, otherwise straight from the input) so valid_out never dips
    // between words while shift_en stays high.
    always_comb begin
        state_n  = state;
        sreg_n   = sreg;
        cnt_n    = cnt;
        hbuf_n   = hbuf;
        hvalid_n = hvalid;

        case (state)
            IDLE: begin
                if (accept) begin
                    sreg_n  = data_in;
                    cnt_n   = CNT_FULL;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (!valid_out || cnt != CNT_ONE) begin
                    if (valid_out) begin
                        sreg_n = {1'b0, sreg[SERIALIZER_WD-1:1]};
                        cnt_n  = cnt - CNT_ONE;
                    end
                    if (accept) begin
                        hbuf_n   = data_in;
                        hvalid_n = 1'b1;
                    end
                end else if (hvalid) begin
                    sreg_n   = hbuf;
                    cnt_n    = CNT_FULL;
                    hvalid_n = 1'b0;
                end else if (accept) begin
                    sreg_n = data_in;
                    cnt_n  = CNT_FULL;
                end else begin
                    sreg_n  = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serializer.sv
// ----------------------------------------------------------------------------
// tb_serializer
// Self-checking bench for serializer. The reference model is a plain queue of
// bits still owed to the serial line: an accepted word appends its WD bits
// LSB-first, every emitted bit pops one. Outstanding words, ready, busy, valid
// and the expected serial bit all follow from the queue length and its head.
// ----------------------------------------------------------------------------
module tb_serializer;

    localparam int WD = 8;

    logic          clk;
    logic          rst;
    logic          valid_in;
    logic [WD-1:0] data_in;
    logic          ready_out;
    logic          shift_en;
    logic          data_out;
    logic          valid_out;
    logic          busy;

    int            vectors;
    int            miscompares;

    bit            bits_q[$];
    int            outstanding;
    logic          exp_valid, exp_data, exp_ready, exp_busy, exp_accept;
    logic [3:0]    exp_vec, obs_vec;

    serializer #(.SERIALIZER_WD(WD)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .shift_en  (shift_en),
        .data_out  (data_out),
        .valid_out (valid_out),
        .busy      (busy)
    );

    // Free-running clock, posedge at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs at the negedge, let combinational outputs
    // settle, and compute what the model expects for this cycle.
    task automatic apply(input logic r, input logic v, input logic [WD-1:0] d, input logic s);
        rst      = r;
        valid_in = v;
        data_in  = d;
        shift_en = s;
        #1;
        outstanding = (bits_q.size() + WD - 1) / WD;
        exp_valid   = (outstanding > 0) && s;
        exp_data    = (outstanding > 0) ? bits_q[0] : 1'b0;
        exp_ready   = !r && (outstanding < 2);
        exp_busy    = (outstanding > 0);
        exp_accept  = v && exp_ready;
        exp_vec     = {exp_valid, exp_data, exp_ready, exp_busy};
        obs_vec     = {valid_out, data_out, ready_out, busy};
    endtask

    // Advance the model across the clock edge and wait for the next negedge.
    task automatic finish_cycle();
        if (rst) begin
            bits_q.delete();
        end else begin
            if (exp_valid) void'(bits_q.pop_front());
            if (exp_accept) for (int i = 0; i < WD; i++) bits_q.push_back(data_in[i]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b0; data_in = '0; shift_en = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            apply(c < 2, 1'b0, '0, 1'b1);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL reset c%0d {valid,data,ready,busy}: got %b want %b", c, obs_vec, exp_vec);
            end
            finish_cycle();
        end
    endtask

    task automatic test_single_word();
        int pulses = 0;
        logic [WD-1:0] got = '0;
        for (int c = 0; c < 13; c++) begin
            apply(1'b0, c == 0, 8'hA5, 1'b1);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL single c%0d {valid,data,ready,busy}: got %b want %b", c, obs_vec, exp_vec);
            end
            if (valid_out === 1'b1) begin
                if (pulses < WD) got[pulses] = data_out;
                pulses++;
            end
            finish_cycle();
        end
        vectors++;
        if (pulses != 8 || got !== 8'hA5) begin
            miscompares++;
            $display("[TB] FAIL single word: got %0d pulses data %h want 8 pulses data a5", pulses, got);
        end
    endtask

    task automatic test_back_to_back();
        logic [WD-1:0] words[3] = '{8'h01, 8'h80, 8'hFF};
        int idx = 0, pulses = 0, first = -1, last = -1;
        for (int c = 0; c < 40; c++) begin
            apply(1'b0, idx < 3, (idx < 3) ? words[idx] : '0, 1'b1);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL b2b c%0d {valid,data,ready,busy}: got %b want %b", c, obs_vec, exp_vec);
            end
            if (exp_accept) idx++;
            if (valid_out === 1'b1) begin
                if (first < 0) first = c;
                last = c;
                pulses++;
            end
            finish_cycle();
        end
        vectors++;
        if (pulses != 24 || (last - first + 1) != 24 || idx != 3) begin
            miscompares++;
            $display("[TB] FAIL b2b stream: got %0d pulses span %0d words %0d want 24/24/3", pulses, last - first + 1, idx);
        end
    endtask

    task automatic test_pacing();
        int pulses = 0;
        logic [WD-1:0] got = '0;
        apply(1'b0, 1'b1, 8'h3C, 1'b1);
        vectors++;
        if (obs_vec !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL pacing load {valid,data,ready,busy}: got %b want %b", obs_vec, exp_vec);
        end
        finish_cycle();
        for (int c = 0; c < 20; c++) begin
            apply(1'b0, 1'b0, '0, (c % 2) == 0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL pacing c%0d {valid,data,ready,busy}: got %b want %b", c, obs_vec, exp_vec);
            end
            if (valid_out === 1'b1) begin
                if (pulses < WD) got[pulses] = data_out;
                pulses++;
            end
            finish_cycle();
        end
        vectors++;
        if (pulses != 8 || got !== 8'h3C) begin
            miscompares++;
            $display("[TB] FAIL pacing word: got %0d pulses data %h want 8 pulses data 3c", pulses, got);
        end
    endtask

    task automatic test_last_bit_bypass();
        int pulses = 0, first = -1, last = -1;
        logic [2*WD-1:0] got = '0;
        for (int c = 0; c < 22; c++) begin
            // 0x0F's last bit goes out at c==8; 0xF0 is offered only then.
            apply(1'b0, (c == 0) || (c == 8), (c == 0) ? 8'h0F : 8'hF0, 1'b1);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL bypass c%0d {valid,data,ready,busy}: got %b want %b", c, obs_vec, exp_vec);
            end
            if (valid_out === 1'b1) begin
                if (first < 0) first = c;
                last = c;
                if (pulses < 2 * WD) got[pulses] = data_out;
                pulses++;
            end
            finish_cycle();
        end
        vectors++;
        if (pulses != 16 || (last - first + 1) != 16 || got !== 16'hF00F) begin
            miscompares++;
            $display("[TB] FAIL bypass stream: got %0d pulses span %0d data %h want 16/16/f00f", pulses, last - first + 1, got);
        end
    endtask

    task automatic test_reset_mid_word();
        int pulses = 0;
        logic [WD-1:0] got = '0;
        for (int c = 0; c < 20; c++) begin
            apply((c == 4) || (c == 5), (c == 0) || (c == 6), (c == 0) ? 8'hFF : 8'h5A, 1'b1);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL rstmid c%0d {valid,data,ready,busy}: got %b want %b", c, obs_vec, exp_vec);
            end
            if (c >= 5 && valid_out === 1'b1) begin
                if (pulses < WD) got[pulses] = data_out;
                pulses++;
            end
            finish_cycle();
        end
        vectors++;
        if (pulses != 8 || got !== 8'h5A) begin
            miscompares++;
            $display("[TB] FAIL rstmid after-reset word: got %0d pulses data %h want 8 pulses data 5a", pulses, got);
        end
    endtask

    // A behavioural deserializer counts valid pulses and rebuilds words.
    task automatic test_loopback();
        logic [WD-1:0] words[3] = '{8'h00, 8'hFF, 8'h96};
        logic [WD-1:0] rx_q[$];
        logic [WD-1:0] shreg = '0;
        int idx = 0, nbits = 0;
        for (int c = 0; c < 40; c++) begin
            apply(1'b0, idx < 3, (idx < 3) ? words[idx] : '0, 1'b1);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL loopback c%0d {valid,data,ready,busy}: got %b want %b", c, obs_vec, exp_vec);
            end
            if (exp_accept) idx++;
            if (valid_out === 1'b1) begin
                shreg[nbits] = data_out;
                nbits++;
                if (nbits == WD) begin
                    rx_q.push_back(shreg);
                    nbits = 0;
                end
            end
            finish_cycle();
        end
        vectors++;
        if (rx_q.size() != 3) begin
            miscompares++;
            $display("[TB] FAIL loopback count: got %0d words want 3", rx_q.size());
        end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== words[i]) begin
                miscompares++;
                $display("[TB] FAIL loopback word%0d: got %h want %h", i, rx_q[i], words[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [WD-1:0] word = WD'($urandom);
        logic          want;
        for (int c = 0; c < 600; c++) begin
            want = ($urandom_range(0, 2) != 0);
            apply(($urandom_range(0, 99) == 0), want, word, ($urandom_range(0, 3) != 0));
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL random c%0d {valid,data,ready,busy}: got %b want %b", c, obs_vec, exp_vec);
            end
            if (exp_accept) word = WD'($urandom);
            finish_cycle();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_pacing();
        test_last_bit_bypass();
        test_reset_mid_word();
        test_loopback();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
